// File: rtl/seq_step_fsm.sv
// Multi-step sequencer: walks STEPS steps on per-step triggers, with a per-step
// watchdog, abort, error-clear and optional wrap-around loop mode.
module seq_step_fsm #(
  parameter int unsigned STEPS   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned LOOP    = 0,
  localparam int unsigned SW     = (STEPS > 1) ? $clog2(STEPS) : 1,
  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
  input  logic [STEPS-1:0] trig,
  output logic [1:0]       state,
  output logic [SW-1:0]    step,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW-1:0]    err_step
);

  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit            WDOG_EN   = (TIMEOUT != 0);
  localparam bit            LOOP_EN   = (LOOP != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  state_e         state_q;
  logic [SW-1:0]  step_q;
  logic [SW-1:0]  err_step_q;
  logic [TW-1:0]  timer_q;
  logic           done_q;
  logic           trig_hit_c;

  // Only the trigger bit belonging to the current step is ever examined.
  assign trig_hit_c = trig[step_q];

  // Sequencer state, step index, watchdog timer and completion/error flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      err_step_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          step_q  <= '0;
          timer_q <= '0;
          if (start && !abort) begin
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            timer_q <= '0;
          end else if (trig_hit_c) begin
            timer_q <= '0;
            if (step_q == LAST_STEP) begin
              // Final step completes: pulse done, then wrap or return to idle.
              done_q <= 1'b1;
              step_q <= '0;
              if (!LOOP_EN) begin
                state_q <= ST_IDLE;
              end
            end else begin
              step_q <= step_q + SW'(1);
            end
          end else if (WDOG_EN && (timer_q == TIMER_MAX)) begin
            state_q    <= ST_ERROR;
            err_step_q <= step_q;
            timer_q    <= '0;
          end else if (WDOG_EN) begin
            timer_q <= timer_q + TW'(1);
          end
        end

        ST_ERROR: begin
          // Failing step index is held until the error is cleared or aborted.
          if (abort || clear) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            timer_q <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          step_q  <= '0;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign step     = step_q;
  assign busy     = (state_q == ST_RUN);
  assign err      = (state_q == ST_ERROR);
  assign done     = done_q;
  assign err_step = err_step_q;

endmodule

// File: tb/tb_seq_step_fsm.sv
// Bench for seq_step_fsm: three parameterisations checked by directed scenarios
// and by random stimulus against a cycle-level behavioural model.
module tb_seq_step_fsm;

  typedef struct {
    int st;
    int step;
    int timer;
    int done;
    int err_step;
  } mdl_t;

  localparam int P_STEPS [3] = '{4, 4, 3};
  localparam int P_TMO   [3] = '{8, 0, 5};
  localparam int P_LOOP  [3] = '{0, 1, 0};

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_v  [3];
  logic       start_v [3];
  logic       abort_v [3];
  logic       clear_v [3];
  logic [3:0] trig_v  [3];

  logic [1:0] state_o [3];
  logic [1:0] step_o  [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       err_o   [3];
  logic [1:0] errs_o  [3];

  seq_step_fsm #(.STEPS(4), .TIMEOUT(8), .LOOP(0)) u0 (
    .clk(clk), .rstn(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .clear(clear_v[0]), .trig(trig_v[0]), .state(state_o[0]), .step(step_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .err_step(errs_o[0]));

  seq_step_fsm #(.STEPS(4), .TIMEOUT(0), .LOOP(1)) u1 (
    .clk(clk), .rstn(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .clear(clear_v[1]), .trig(trig_v[1]), .state(state_o[1]), .step(step_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .err_step(errs_o[1]));

  seq_step_fsm #(.STEPS(3), .TIMEOUT(5), .LOOP(0)) u2 (
    .clk(clk), .rstn(rstn_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .clear(clear_v[2]), .trig(trig_v[2][2:0]), .state(state_o[2]), .step(step_o[2]),
    .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]), .err_step(errs_o[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs(int k);
    return {state_o[k], step_o[k], busy_o[k], done_o[k], err_o[k], errs_o[k]};
  endfunction

  // Expected observation: busy and err follow directly from the state value.
  function automatic logic [8:0] pk(int st, int stp, int dn, int es);
    return {2'(st), 2'(stp), 1'(st == 1), 1'(dn), 1'(st == 2), 2'(es)};
  endfunction

  // Next-cycle behaviour of instance k, expressed from the sequencing rules.
  function automatic mdl_t mnext(mdl_t m, int k);
    mdl_t n;
    int   steps;
    bit   hit;
    n      = m;
    n.done = 0;
    steps  = P_STEPS[k];
    hit    = ((int'(trig_v[k]) >> m.step) & 1) == 1;
    if (!rstn_v[k]) begin
      n.st = 0; n.step = 0; n.timer = 0; n.done = 0; n.err_step = 0;
      return n;
    end
    if (m.st == 0) begin
      if (start_v[k] && !abort_v[k]) begin
        n.st = 1; n.step = 0; n.timer = 0;
      end
    end else if (m.st == 1) begin
      if (abort_v[k]) begin
        n.st = 0; n.step = 0; n.timer = 0;
      end else if (hit) begin
        n.timer = 0;
        n.step  = (m.step + 1) % steps;
        if (m.step == steps - 1) begin
          n.done = 1;
          if (P_LOOP[k] == 0) n.st = 0;
        end
      end else if (P_TMO[k] != 0 && m.timer + 1 == P_TMO[k]) begin
        n.st = 2; n.err_step = m.step; n.timer = 0;
      end else if (P_TMO[k] != 0) begin
        n.timer = m.timer + 1;
      end
    end else begin
      if (abort_v[k] || clear_v[k]) begin
        n.st = 0; n.step = 0; n.timer = 0;
      end
    end
    return n;
  endfunction

  task automatic rst_all();
    for (int k = 0; k < 3; k++) begin
      rstn_v[k] = 1'b0; start_v[k] = 1'b0; abort_v[k] = 1'b0;
      clear_v[k] = 1'b0; trig_v[k] = 4'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) rstn_v[k] = 1'b1;
  endtask

  task automatic test_reset();
    rst_all();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== pk(0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b expected %b", k, obs(k), pk(0, 0, 0, 0));
      end
    end
    start_v[0] = 1'b1; tick();
    start_v[0] = 1'b0; trig_v[0] = 4'b0001; tick();
    trig_v[0] = 4'b0010; tick();
    checks++;
    if (obs(0) !== pk(1, 2, 0, 0)) begin
      errors++;
      $display("FAIL reset_pre_step2: got %b expected %b", obs(0), pk(1, 2, 0, 0));
    end
    rstn_v[0] = 1'b0; start_v[0] = 1'b1; trig_v[0] = 4'b1111; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_run: got %b expected %b", obs(0), pk(0, 0, 0, 0));
    end
    rstn_v[0] = 1'b1; start_v[0] = 1'b0; trig_v[0] = 4'b0; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected %b", obs(0), pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_sequence();
    start_v[0] = 1'b1; abort_v[0] = 1'b1; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_with_abort: got %b expected %b", obs(0), pk(0, 0, 0, 0));
    end
    abort_v[0] = 1'b0; tick();
    checks++;
    if (obs(0) !== pk(1, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_run: got %b expected %b", obs(0), pk(1, 0, 0, 0));
    end
    start_v[0] = 1'b0; trig_v[0] = 4'b1110; tick();
    checks++;
    if (obs(0) !== pk(1, 0, 0, 0)) begin
      errors++;
      $display("FAIL wrong_bits: got %b expected %b", obs(0), pk(1, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      logic [8:0] e;
      trig_v[0] = 4'(1 << i);
      tick();
      e = (i < 3) ? pk(1, i + 1, 0, 0) : pk(0, 0, 1, 0);
      checks++;
      if (obs(0) !== e) begin
        errors++;
        $display("FAIL seq_step%0d: got %b expected %b", i, obs(0), e);
      end
    end
    trig_v[0] = 4'b0; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL done_one_cycle: got %b expected %b", obs(0), pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_timeout();
    start_v[0] = 1'b1; tick();
    start_v[0] = 1'b0; trig_v[0] = 4'b0001; tick();
    trig_v[0] = 4'b0;
    for (int j = 1; j < 8; j++) begin
      tick();
      checks++;
      if (obs(0) !== pk(1, 1, 0, 0)) begin
        errors++;
        $display("FAIL timeout_wait%0d: got %b expected %b", j, obs(0), pk(1, 1, 0, 0));
      end
    end
    tick();
    checks++;
    if (obs(0) !== pk(2, 1, 0, 1)) begin
      errors++;
      $display("FAIL timeout_error: got %b expected %b", obs(0), pk(2, 1, 0, 1));
    end
    start_v[0] = 1'b1; trig_v[0] = 4'b1111; tick();
    checks++;
    if (obs(0) !== pk(2, 1, 0, 1)) begin
      errors++;
      $display("FAIL error_ignores_start: got %b expected %b", obs(0), pk(2, 1, 0, 1));
    end
    start_v[0] = 1'b0; trig_v[0] = 4'b0; clear_v[0] = 1'b1; abort_v[0] = 1'b1; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 1)) begin
      errors++;
      $display("FAIL clear_to_idle: got %b expected %b", obs(0), pk(0, 0, 0, 1));
    end
    clear_v[0] = 1'b0; abort_v[0] = 1'b0;
  endtask

  task automatic test_late_trigger();
    start_v[0] = 1'b1; tick();
    start_v[0] = 1'b0;
    for (int j = 0; j < 7; j++) tick();
    checks++;
    if (obs(0) !== pk(1, 0, 0, 1)) begin
      errors++;
      $display("FAIL late_wait: got %b expected %b", obs(0), pk(1, 0, 0, 1));
    end
    trig_v[0] = 4'b0001; tick();
    checks++;
    if (obs(0) !== pk(1, 1, 0, 1)) begin
      errors++;
      $display("FAIL late_trigger_advances: got %b expected %b", obs(0), pk(1, 1, 0, 1));
    end
    trig_v[0] = 4'b0; abort_v[0] = 1'b1; tick();
    checks++;
    if (obs(0) !== pk(0, 0, 0, 1)) begin
      errors++;
      $display("FAIL abort_run: got %b expected %b", obs(0), pk(0, 0, 0, 1));
    end
    abort_v[0] = 1'b0;
  endtask

  task automatic test_no_timeout();
    start_v[1] = 1'b1; tick();
    start_v[1] = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick();
      checks++;
      if (obs(1) !== pk(1, 0, 0, 0)) begin
        errors++;
        $display("FAIL no_timeout%0d: got %b expected %b", j, obs(1), pk(1, 0, 0, 0));
      end
    end
    abort_v[1] = 1'b1; tick();
    abort_v[1] = 1'b0;
    checks++;
    if (obs(1) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL no_timeout_abort: got %b expected %b", obs(1), pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back_loop();
    start_v[1] = 1'b1; tick();
    start_v[1] = 1'b0; trig_v[1] = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      logic [8:0] e;
      tick();
      e = pk(1, (c + 1) % 4, int'((c + 1) % 4 == 0), 0);
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL loop_cycle%0d: got %b expected %b", c, obs(1), e);
      end
    end
    abort_v[1] = 1'b1; tick();
    checks++;
    if (obs(1) !== pk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL loop_abort_last: got %b expected %b", obs(1), pk(0, 0, 0, 0));
    end
    abort_v[1] = 1'b0; trig_v[1] = 4'b0;
  endtask

  task automatic test_steps3();
    start_v[2] = 1'b1; tick();
    start_v[2] = 1'b0; trig_v[2] = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      logic [8:0] e;
      tick();
      e = (i < 2) ? pk(1, i + 1, 0, 0) : pk(0, 0, 1, 0);
      checks++;
      if (obs(2) !== e) begin
        errors++;
        $display("FAIL s3_step%0d: got %b expected %b", i, obs(2), e);
      end
    end
    trig_v[2] = 4'b0;
    start_v[2] = 1'b1; tick();
    start_v[2] = 1'b0; trig_v[2] = 4'b0001; tick();
    trig_v[2] = 4'b0010; tick();
    trig_v[2] = 4'b0;
    for (int j = 1; j < 5; j++) begin
      tick();
      checks++;
      if (obs(2) !== pk(1, 2, 0, 0)) begin
        errors++;
        $display("FAIL s3_wait%0d: got %b expected %b", j, obs(2), pk(1, 2, 0, 0));
      end
    end
    tick();
    checks++;
    if (obs(2) !== pk(2, 2, 0, 2)) begin
      errors++;
      $display("FAIL s3_timeout: got %b expected %b", obs(2), pk(2, 2, 0, 2));
    end
    trig_v[2] = 4'b0100; tick();
    checks++;
    if (obs(2) !== pk(2, 2, 0, 2)) begin
      errors++;
      $display("FAIL s3_error_ignores_trig: got %b expected %b", obs(2), pk(2, 2, 0, 2));
    end
    trig_v[2] = 4'b0; clear_v[2] = 1'b1; tick();
    clear_v[2] = 1'b0;
    checks++;
    if (obs(2) !== pk(0, 0, 0, 2)) begin
      errors++;
      $display("FAIL s3_clear: got %b expected %b", obs(2), pk(0, 0, 0, 2));
    end
  endtask

  task automatic test_random();
    mdl_t m [3];
    mdl_t nm [3];
    rst_all();
    for (int k = 0; k < 3; k++) begin
      m[k].st = 0; m[k].step = 0; m[k].timer = 0; m[k].done = 0; m[k].err_step = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        rstn_v[k]  = ($urandom_range(63) != 0);
        start_v[k] = ($urandom_range(3) == 0);
        abort_v[k] = ($urandom_range(31) == 0);
        clear_v[k] = ($urandom_range(7) == 0);
        trig_v[k]  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0;
        nm[k] = mnext(m[k], k);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        logic [8:0] e;
        m[k] = nm[k];
        e = pk(m[k].st, m[k].step, m[k].done, m[k].err_step);
        checks++;
        if (obs(k) !== e) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got %b expected %b", k, n, obs(k), e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout();
    test_late_trigger();
    test_no_timeout();
    test_back_to_back_loop();
    test_steps3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_step_fsm.md
# seq_step_fsm

Parametrised multi-step sequencer FSM: the generalised successor to the team's two-state INIT/RUNNING controllers. It walks through `STEPS` steps, each advanced by a per-step trigger bit, with a per-step watchdog timeout, abort and error-clear, plus an optional wrap-around (loop) mode. It sits between control inputs (start, triggers) and downstream logic that consumes the current step index and the completion/error flags.

## Interface
Parameters:
- `STEPS`, default 4: number of sequence steps; legal range is 2 or more.
- `TIMEOUT`, default 8: cycles allowed per step without a trigger. 0 disables the watchdog.
- `LOOP`, default 0: 0 returns to IDLE after the last step; 1 wraps to step 0.
- Derived `SW = $clog2(STEPS)` and `TW = $clog2(TIMEOUT+1)`, with a minimum of 1 for each.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin sequence; honoured only in IDLE.
- `abort`  in  1  force return to IDLE from any state.
- `clear`  in  1  leave ERROR back to IDLE.
- `trig`  in  STEPS  trigger vector; only `trig[step]` is examined.
- `state`  out  2  encoding: IDLE=0, RUN=1, ERROR=2; 3 is unused.
- `step`  out  SW  current step index.
- `busy`  out  1  high when `state==RUN`.
- `done`  out  1  one-cycle pulse when the last step completes.
- `err`  out  1  high when `state==ERROR`.
- `err_step`  out  SW  index of the step that timed out; held until the next timeout or reset.

## Operation
- Internal registers: `state`, `step`, `timer[TW-1:0]`, `done`, `err_step`. All outputs are registered or decoded directly from registers. There are no combinational paths from inputs to outputs.
- Reset (`rstn=0` at a clock edge) forces: `state`=IDLE, `step`=0, `timer`=0, `done`=0, `err_step`=0. Therefore `busy`=0 and `err`=0. Reset wins over all other inputs, including mid-sequence.
- `done` defaults to 0 every cycle unless set by a last-step completion.
- IDLE:
  - `start=1` and `abort=0` → RUN, with `step`=0 and `timer`=0.
  - Otherwise stay in IDLE; `step` holds 0.
- RUN, priority order `abort` > trigger > timeout:
  - `abort=1` → IDLE, `step`=0, `timer`=0, no `done` pulse.
  - Trigger present (`trig[step]=1`), not on the last step → `step`+1, `timer`=0.
  - Trigger present on the last step (`step==STEPS-1`) → `done`=1 for one cycle, `timer`=0.
    - LOOP=0: go to IDLE with `step`=0.
    - LOOP=1: stay in RUN with `step`=0.
  - No trigger, `TIMEOUT!=0` and `timer==TIMEOUT-1` → ERROR, `err_step`=`step`, `timer`=0.
  - No trigger otherwise → `timer`+1. When `TIMEOUT==0`, `timer` stays at 0.
- ERROR:
  - `abort=1` or `clear=1` → IDLE, `step`=0.
  - `start` and `trig` are ignored.
  - `step` holds the failing index while in ERROR.
- Trigger bits other than `trig[step]` are ignored. A trigger held high advances one step per cycle.
- `start` is ignored in RUN and ERROR, so there is no restart mid-sequence.
- Widths: `step` increments modulo STEPS only through the explicit last-step rule and never wraps arithmetically. `timer` never exceeds `TIMEOUT-1`.

## Timing
- Start latency: `start` sampled at edge N gives `busy`=1 and `step`=0 after edge N.
- Step latency: `trig[step]` sampled at edge N gives the new `step` visible after edge N. This allows one step per cycle at most.
- Timeout: a step entered at edge E with no trigger reaches ERROR after edge E+TIMEOUT. With the default TIMEOUT=8, the step is in RUN for 8 cycles, then ERROR.
- A trigger in the same cycle as `timer==TIMEOUT-1` advances the step; no error occurs.
- `done` is high in exactly the one cycle following the final trigger edge, coincident with `state`=IDLE (LOOP=0) or `step`=0 (LOOP=1).
- Simultaneous `abort` and final trigger: abort wins, and `done` stays 0.
- Simultaneous `clear` and `abort` in ERROR: IDLE. `err_step` is unchanged.

## Test plan
All scenarios use defaults (STEPS=4, TIMEOUT=8, LOOP=0) unless stated.
- Reset mid-RUN at `step`=2 → next cycle `state`=0, `step`=0, `busy`=0, `done`=0, `err`=0, `err_step`=0.
- `start`, then `trig` = 0001, 0010, 0100, 1000 on consecutive cycles → `step` goes 0,1,2,3, then `done`=1 for one cycle with `state`=0. Wrong-bit triggers (e.g. `trig`=1110 at step 0) cause no advance.
- `start`, `trig`=0001, then no trigger → `state`=2 exactly 8 cycles after entering step 1, with `err_step`=1 and `err`=1. Then `start` is ignored and `clear` returns to `state`=0; `err_step` stays 1.
- Trigger on the 8th cycle of a step (`timer`=7) → advances, no ERROR. `TIMEOUT`=0 with 100 idle cycles in RUN → never ERROR.
- LOOP=1, `trig`=1111 held → `step` cycles 0,1,2,3,0,1…, `done` pulses every 4th cycle, and `busy` stays 1. `abort` coincident with `step`=3 → IDLE, no `done`.
- STEPS=3 (SW=2): a full sequence completes at `step`=2, and the `step` output never shows 3.
